// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit: widths, defaults,
// FSM state encoding and PC arithmetic helpers.
package fetch_pkg;

  localparam int XLEN = 64;
  localparam int ILEN = 32;
  localparam logic [XLEN-1:0] DEF_RESET_PC = 64'h0;
  localparam int DEF_DEPTH = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FETCH   = 2'd1,
    DISCARD = 2'd2
  } fetch_state_e;

  // Sequential fetch step; wraps naturally at the top of the 64-bit space.
  function automatic logic [XLEN-1:0] next_pc(input logic [XLEN-1:0] pc);
    return pc + XLEN'(4);
  endfunction

  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
    return {pc[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Bundle of the fetch unit's memory, decode and redirect handshakes.
// master = fetch unit side, slave = memory/decode/branch side.
interface instruction_fetch_unit_if;
  import fetch_pkg::*;

  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_resp_valid;
  logic [ILEN-1:0] imem_resp_data;
  logic            inst_valid;
  logic            inst_ready;
  logic [ILEN-1:0] inst_data;
  logic [XLEN-1:0] inst_pc;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;

  modport master (
    output imem_req_valid, imem_req_addr, inst_valid, inst_data, inst_pc,
    input  imem_req_ready, imem_resp_valid, imem_resp_data, inst_ready,
    input  redirect_valid, redirect_pc
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, inst_valid, inst_data, inst_pc,
    output imem_req_ready, imem_resp_valid, imem_resp_data, inst_ready,
    output redirect_valid, redirect_pc
  );

endinterface

// File: rtl/fetch_fifo.sv
// Synchronous fetch buffer holding {pc, instruction} entries, with flush and
// occupancy count. Output reads as zero while empty.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int WIDTH = XLEN + ILEN
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush_i,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           wdata_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           rdata_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rd_ptr_q, wr_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push, do_pop;

  assign do_pop  = pop_i && (count_q != '0);
  assign do_push = push_i && ((count_q != CW'(DEPTH)) || do_pop);

  // Flush beats any simultaneous push or pop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = (count_q == '0) ? '0 : mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: issues sequential fetches, buffers in-order responses
// for decode, and flushes/discards the old path on a redirect.
module instruction_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = DEF_RESET_PC,
  parameter int              DEPTH    = DEF_DEPTH
) (
  input  logic                     clk,
  input  logic                     reset,
  instruction_fetch_unit_if.master bus
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);

  fetch_state_e          state_q, state_d;
  logic [XLEN-1:0]       fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0]       resp_pc_q, resp_pc_d;
  logic [CW-1:0]         outst_q, outst_d;
  logic [CW-1:0]         drop_q, drop_d;
  logic [CW-1:0]         fifo_count;
  logic [CW:0]           occupancy;
  logic [XLEN+ILEN-1:0]  head;
  logic                  accept, push;

  // Buffered plus in-flight never exceeds DEPTH, so every response has a slot.
  assign occupancy          = {1'b0, fifo_count} + {1'b0, outst_q};
  assign bus.imem_req_valid = (state_q == FETCH) && (occupancy < DEPTH_C);
  assign bus.imem_req_addr  = fetch_pc_q;
  assign accept             = bus.imem_req_valid && bus.imem_req_ready;
  assign push               = bus.imem_resp_valid && (state_q == FETCH) && !bus.redirect_valid;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    drop_d     = drop_q;
    outst_d    = outst_q + CW'(accept) - CW'(bus.imem_resp_valid);
    if (accept) fetch_pc_d = next_pc(fetch_pc_q);
    if (push)   resp_pc_d  = next_pc(resp_pc_q);

    unique case (state_q)
      IDLE:    state_d = FETCH;
      FETCH:   state_d = FETCH;
      DISCARD: begin
        if (bus.imem_resp_valid) drop_d = drop_q - CW'(1);
        if (drop_d == '0) state_d = FETCH;
      end
      default: state_d = IDLE;
    endcase

    // Everything still in flight after this cycle belongs to the old path,
    // including a request accepted right now.
    if (bus.redirect_valid) begin
      fetch_pc_d = align_pc(bus.redirect_pc);
      resp_pc_d  = align_pc(bus.redirect_pc);
      drop_d     = outst_d;
      state_d    = (outst_d != '0) ? DISCARD : FETCH;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      outst_q    <= '0;
      drop_q     <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      outst_q    <= outst_d;
      drop_q     <= drop_d;
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (XLEN + ILEN)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .flush_i (bus.redirect_valid),
    .push_i  (push),
    .wdata_i ({resp_pc_q, bus.imem_resp_data}),
    .pop_i   (bus.inst_ready),
    .rdata_o (head),
    .count_o (fifo_count)
  );

  assign bus.inst_valid = (fifo_count != '0);
  assign bus.inst_data  = head[ILEN-1:0];
  assign bus.inst_pc    = head[XLEN+ILEN-1:ILEN];

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: memory model with latency and
// gaps, scoreboard of expected {pc, data}, directed tables and random traffic.
module tb_instruction_fetch_unit;
  import fetch_pkg::*;

  localparam int          DEPTH = 4;
  localparam logic [63:0] RPC   = 64'h0;

  typedef struct { logic [63:0] addr; int gen; int due; } pend_t;
  typedef struct { logic [63:0] pc; logic [31:0] data; } exp_t;
  typedef struct { logic req_v; logic [63:0] addr; logic inst_v; logic [63:0] pc; } row_t;
  typedef struct { int lat; int wait_n; logic [63:0] tgt; logic [63:0] first; } redir_t;

  logic clk = 1'b0;
  logic reset = 1'b0;

  instruction_fetch_unit_if bus();

  instruction_fetch_unit #(.RESET_PC(RPC), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  pend_t       pend[$];
  exp_t        expq[$];
  row_t        rows[8];
  redir_t      sc[4];
  int          nchk = 0, npass = 0, cyc = 0, gen = 0, acc_cnt = 0, last_due = 0;
  int          lat_min = 1, lat_max = 1, ready_pct = 100, resp_pct = 100, iready_pct = 100;
  int          row_idx = -1;
  logic [63:0] exp_addr = RPC;
  bit          redir_req = 1'b0;
  logic [63:0] redir_tgt = '0;
  bit          want_first = 1'b0;
  logic [63:0] first_exp = '0;
  bit          prev_hold = 1'b0;
  logic [63:0] prev_addr = '0;
  logic        last_rv = 1'b0;

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return (a[33:2] * 32'h9E37_79B9) ^ 32'h1357_2468;
  endfunction

  task automatic check(input bit ok, input string name, input logic [63:0] act, input logic [63:0] req);
    nchk++;
    if (ok) npass++;
    else $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, req, cyc);
  endtask

  task automatic check_row(input int i, input logic rv, input logic [63:0] a,
                           input logic iv, input logic [63:0] ipc);
    check(rv === rows[i].req_v, $sformatf("row%0d_req_valid", i), 64'(rv), 64'(rows[i].req_v));
    if (rows[i].req_v) check(a === rows[i].addr, $sformatf("row%0d_req_addr", i), a, rows[i].addr);
    check(iv === rows[i].inst_v, $sformatf("row%0d_inst_valid", i), 64'(iv), 64'(rows[i].inst_v));
    if (rows[i].inst_v) check(ipc === rows[i].pc, $sformatf("row%0d_inst_pc", i), ipc, rows[i].pc);
  endtask

  task automatic drive_idle();
    bus.imem_req_ready  = 1'b0;
    bus.imem_resp_valid = 1'b0;
    bus.imem_resp_data  = '0;
    bus.inst_ready      = 1'b0;
    bus.redirect_valid  = 1'b0;
    bus.redirect_pc     = '0;
  endtask

  // Asserts reset between edges, checks the immediate effect, releases on a negedge.
  task automatic do_reset();
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    check(bus.inst_valid === 1'b0, "rst_inst_valid", 64'(bus.inst_valid), 64'h0);
    check(bus.inst_data === 32'h0, "rst_inst_data", 64'(bus.inst_data), 64'h0);
    check(bus.inst_pc === 64'h0, "rst_inst_pc", bus.inst_pc, 64'h0);
    check(bus.imem_req_valid === 1'b0, "rst_req_valid", 64'(bus.imem_req_valid), 64'h0);
    check(bus.imem_req_addr === RPC, "rst_req_addr", bus.imem_req_addr, RPC);
    drive_idle();
    pend.delete();
    expq.delete();
    gen++;
    exp_addr   = RPC;
    prev_hold  = 1'b0;
    want_first = 1'b0;
    redir_req  = 1'b0;
    last_due   = 0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
  endtask

  // One clock: sample DUT at the negedge, score it, then drive next inputs.
  task automatic step();
    logic        rv, iv;
    logic [63:0] a, ipc;
    logic [31:0] idat;
    bit          acc, dlv, rdr, ir, rr;
    pend_t       r;
    exp_t        e;
    int          d;
    @(negedge clk);
    cyc++;
    rv = bus.imem_req_valid;
    a = bus.imem_req_addr;
    iv = bus.inst_valid;
    ipc = bus.inst_pc;
    idat = bus.inst_data;
    last_rv = rv;
    if (prev_hold) check(rv === 1'b1 && a === prev_addr, "req_hold", a, prev_addr);
    check(iv === (expq.size() > 0), "inst_valid", 64'(iv), 64'(expq.size()));
    if (pend.size() > 0 && pend[0].gen != gen) check(rv === 1'b0, "req_in_discard", 64'(rv), 64'h0);
    if (row_idx >= 1 && row_idx < 8) begin
      check_row(row_idx, rv, a, iv, ipc);
      row_idx++;
    end

    rdr = redir_req;
    redir_req = 1'b0;
    ir = (int'($urandom_range(99)) < iready_pct);
    rr = (int'($urandom_range(99)) < ready_pct);
    bus.redirect_valid = rdr;
    bus.redirect_pc    = rdr ? redir_tgt : 64'h0;
    bus.inst_ready     = ir;
    bus.imem_req_ready = rr;

    dlv = (iv === 1'b1) && ir && !rdr;
    if (dlv) begin
      check(expq.size() != 0, "inst_unexpected", ipc, 64'h0);
      if (expq.size() != 0) begin
        e = expq.pop_front();
        check(ipc === e.pc, "inst_pc", ipc, e.pc);
        check(idat === e.data, "inst_data", 64'(idat), 64'(e.data));
        if (want_first) begin
          check(ipc === first_exp, "first_pc", ipc, first_exp);
          want_first = 1'b0;
        end
      end
    end

    if (pend.size() > 0 && pend[0].due <= cyc && int'($urandom_range(99)) < resp_pct) begin
      r = pend.pop_front();
      bus.imem_resp_valid = 1'b1;
      bus.imem_resp_data  = mem_word(r.addr);
      if (r.gen == gen && !rdr) begin
        e.pc = r.addr;
        e.data = mem_word(r.addr);
        expq.push_back(e);
      end
    end else begin
      bus.imem_resp_valid = 1'b0;
      bus.imem_resp_data  = $urandom();
    end

    acc = (rv === 1'b1) && rr;
    if (acc) begin
      check(a === exp_addr, "req_addr", a, exp_addr);
      d = cyc + int'($urandom_range(lat_max, lat_min));
      if (d < last_due) d = last_due;
      last_due = d;
      r.addr = a;
      r.gen = gen;
      r.due = d;
      pend.push_back(r);
      exp_addr = exp_addr + 64'd4;
      acc_cnt++;
      check(pend.size() + expq.size() <= DEPTH, "occupancy",
            64'(pend.size() + expq.size()), 64'(DEPTH));
    end

    if (rdr) begin
      gen++;
      expq.delete();
      exp_addr = {redir_tgt[63:2], 2'b00};
    end
    prev_hold = (rv === 1'b1) && !acc && !rdr;
    prev_addr = a;
  endtask

  initial begin
    int n;
    drive_idle();
    rows[0] = '{1'b0, RPC,          1'b0, 64'h0};
    rows[1] = '{1'b1, RPC,          1'b0, 64'h0};
    rows[2] = '{1'b1, RPC + 64'd4,  1'b0, 64'h0};
    rows[3] = '{1'b1, RPC + 64'd8,  1'b1, RPC};
    rows[4] = '{1'b1, RPC + 64'd12, 1'b1, RPC + 64'd4};
    rows[5] = '{1'b1, RPC + 64'd16, 1'b1, RPC + 64'd8};
    rows[6] = '{1'b1, RPC + 64'd20, 1'b1, RPC + 64'd12};
    rows[7] = '{1'b1, RPC + 64'd24, 1'b1, RPC + 64'd16};
    sc[0] = '{3, 3, 64'h100, 64'h100};
    sc[1] = '{1, 1, 64'h203, 64'h200};
    sc[2] = '{1, 1, 64'hFFFF_FFFF_FFFF_FFF8, 64'hFFFF_FFFF_FFFF_FFF8};
    sc[3] = '{2, 2, 64'h7, 64'h4};

    // Zero-wait memory, decode always ready: cycle-exact table.
    lat_min = 1; lat_max = 1; ready_pct = 100; resp_pct = 100; iready_pct = 100;
    do_reset();
    check_row(0, bus.imem_req_valid, bus.imem_req_addr, bus.inst_valid, bus.inst_pc);
    row_idx = 1;
    repeat (12) step();
    row_idx = -1;

    // Decode stalled: requests stop once the buffer and flight slots are used up.
    iready_pct = 0;
    do_reset();
    acc_cnt = 0;
    repeat (20) step();
    check(acc_cnt == DEPTH, "stall_requests", 64'(acc_cnt), 64'(DEPTH));
    check(last_rv === 1'b0, "stall_req_valid", 64'(last_rv), 64'h0);
    iready_pct = 100;
    want_first = 1'b1;
    first_exp = RPC;
    repeat (12) step();
    check(want_first == 1'b0, "stall_resume", 64'(want_first), 64'h0);

    // Redirect scenarios.
    for (int i = 0; i < 4; i++) begin
      lat_min = sc[i].lat; lat_max = sc[i].lat; iready_pct = 100;
      do_reset();
      for (n = 0; n < 30 && pend.size() != sc[i].wait_n; n++) step();
      check(pend.size() == sc[i].wait_n, "redirect_setup", 64'(pend.size()), 64'(sc[i].wait_n));
      redir_req = 1'b1;
      redir_tgt = sc[i].tgt;
      want_first = 1'b1;
      first_exp = sc[i].first;
      repeat (25) step();
      check(want_first == 1'b0, "redirect_delivered", 64'(want_first), 64'h0);
    end

    // Reset with two entries buffered.
    lat_min = 1; lat_max = 1; iready_pct = 0;
    do_reset();
    for (n = 0; n < 30 && expq.size() != 2; n++) step();
    check(expq.size() == 2, "two_buffered", 64'(expq.size()), 64'h2);
    do_reset();
    iready_pct = 100;
    want_first = 1'b1;
    first_exp = RPC;
    repeat (10) step();
    check(want_first == 1'b0, "post_reset_first", 64'(want_first), 64'h0);

    // Random handshakes, gaps and redirects.
    lat_min = 1; lat_max = 4; ready_pct = 70; resp_pct = 70; iready_pct = 60;
    do_reset();
    repeat (3000) begin
      if ($urandom_range(99) < 2) begin
        redir_req = 1'b1;
        redir_tgt = {$urandom(), $urandom()};
      end
      step();
    end
    ready_pct = 0; resp_pct = 100; iready_pct = 100;
    for (n = 0; n < 200 && (pend.size() != 0 || expq.size() != 0); n++) step();
    check(pend.size() == 0 && expq.size() == 0, "drain",
          64'(pend.size() + expq.size()), 64'h0);

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
